// File: rtl/phase_report_tx.sv
// Frames each synchronized measurement-done event into a UART packet: HDR0 HDR1 [SEQ] W3 W2 W1 W0 CHK.
// Optional build macro PHASE_REPORT_SEQ_EN inserts a per-packet sequence byte after HDR1 (also folded into CHK).
module phase_report_tx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55,
    parameter int          BUSY_WAIT   = 16
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        send_bytes_start,
    input  logic [31:0] cnt_f,
    input  logic        Uart_TX_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        Bytes_busy,
    output logic [7:0]  drop_cnt
);

`ifdef PHASE_REPORT_SEQ_EN
    localparam int NBYTES = 8;
`else
    localparam int NBYTES = 7;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);
    localparam int         WW       = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_prev_q, sync_prev_d;
    logic [31:0]            pend_word_q, pend_word_d;
    logic                   pending_q, pending_d;
    logic [31:0]            word_q, word_d;
    logic [2:0]             idx_q, idx_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   bytes_busy_q, bytes_busy_d;
    logic [7:0]             drop_q, drop_d;
`ifdef PHASE_REPORT_SEQ_EN
    logic [7:0]             seq_q, seq_d;
`endif

    logic                   trig;
    logic [7:0]             chk;
    logic [NBYTES*8-1:0]    pkt;
    logic [2:0]             sel;
    logic [7:0]             byte_sel;

    assign trig = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    // Packet is assembled first-byte-in-MSB so idx 0 selects the top byte.
    always_comb begin
        chk = word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
`ifdef PHASE_REPORT_SEQ_EN
        chk = chk ^ seq_q;
        pkt = {HDR0, HDR1, seq_q, word_q, chk};
`else
        pkt = {HDR0, HDR1, word_q, chk};
`endif
        sel      = LAST_IDX - idx_q;
        byte_sel = pkt[{sel, 3'b000} +: 8];
    end

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], send_bytes_start};
        sync_prev_d  = sync_q[SYNC_STAGES-1];
        pend_word_d  = pend_word_q;
        pending_d    = pending_q;
        word_d       = word_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        bytes_busy_d = bytes_busy_q;
        drop_d       = drop_q;
`ifdef PHASE_REPORT_SEQ_EN
        seq_d        = seq_q;
`endif

        // A trigger in LOAD replaces the word being consumed, so it is not a loss.
        if (trig) begin
            pend_word_d = cnt_f;
            pending_d   = 1'b1;
            if (pending_q && (state_q != LOAD) && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q || trig) begin
                    state_d      = LOAD;
                    bytes_busy_d = 1'b1;
                end
            end
            LOAD: begin
                word_d = pend_word_q;
                if (!trig) begin
                    pending_d = 1'b0;
                end
                idx_d   = 3'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!Uart_TX_busy) begin
                    tx_data_d  = byte_sel;
                    tx_start_d = 1'b1;
                    wait_d     = '0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A transmitter that never raises busy is assumed to have taken the byte.
                if (Uart_TX_busy) begin
                    state_d = WAIT_LO;
                end else if (wait_q == WW'(BUSY_WAIT - 1)) begin
                    state_d = NEXT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            WAIT_LO: begin
                if (!Uart_TX_busy) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d      = IDLE;
                    bytes_busy_d = 1'b0;
`ifdef PHASE_REPORT_SEQ_EN
                    seq_d        = seq_q + 8'd1;
`endif
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            sync_prev_q  <= 1'b0;
            pend_word_q  <= '0;
            pending_q    <= 1'b0;
            word_q       <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            bytes_busy_q <= 1'b0;
            drop_q       <= '0;
`ifdef PHASE_REPORT_SEQ_EN
            seq_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            sync_prev_q  <= sync_prev_d;
            pend_word_q  <= pend_word_d;
            pending_q    <= pending_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            bytes_busy_q <= bytes_busy_d;
            drop_q       <= drop_d;
`ifdef PHASE_REPORT_SEQ_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign Bytes_busy = bytes_busy_q;
    assign drop_cnt   = drop_q;

endmodule
